// File: rtl/nbit_n_one_arb_mux.sv
// N-input to 1-output registered bus multiplexer with valid/ready on every port.
// The source is chosen by a round-robin arbiter or by a forced external select.
module nbit_n_one_arb_mux #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] bus_in,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic                         force_en,
    input  logic [SEL_WIDTH-1:0]         force_sel,
    output logic [DATA_WIDTH-1:0]        bus_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_WIDTH-1:0]         bus_ch
);

    logic [DATA_WIDTH-1:0] bus_out_q;
    logic                  out_valid_q;
    logic [SEL_WIDTH-1:0]  bus_ch_q;
    logic [SEL_WIDTH-1:0]  rr_ptr_q;
    logic [SEL_WIDTH-1:0]  rr_ptr_d;

    logic                  load_en;
    logic                  grant_vld;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  xfer;

    assign load_en = !out_valid_q || out_ready;
    assign xfer    = grant_vld && load_en;

    // Round-robin scan from rr_ptr with wrap is done as two linear passes:
    // first channels at or above rr_ptr, then the remaining lower channels.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (force_en) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (force_sel == SEL_WIDTH'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_WIDTH'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!grant_vld && in_valid[i] && (32'(rr_ptr_q) <= i)) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_WIDTH'(i);
                end
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!grant_vld && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_idx == SEL_WIDTH'(i)) begin
                grant_data = bus_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready is gated by reset so no handshake can complete while it is held.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            in_ready[i] = reset_n && xfer && (grant_idx == SEL_WIDTH'(i));
        end
    end

    assign rr_ptr_d = (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + SEL_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_out_q   <= '0;
            out_valid_q <= 1'b0;
            bus_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else if (xfer) begin
            bus_out_q   <= grant_data;
            bus_ch_q    <= grant_idx;
            out_valid_q <= 1'b1;
            if (!force_en) begin
                rr_ptr_q <= rr_ptr_d;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus_out   = bus_out_q;
    assign out_valid = out_valid_q;
    assign bus_ch    = bus_ch_q;

endmodule

// File: tb/tb_nbit_n_one_arb_mux.sv
// Randomised and directed check of nbit_n_one_arb_mux against a cycle-level model
// of the arbitration rules, plus a 3-channel 16-bit instance for wrap and width.
module tb_nbit_n_one_arb_mux;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [31:0] bus_in;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        force_en;
    logic [2:0]  force_sel;
    logic [7:0]  bus_out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  bus_ch;

    logic [47:0] b_bus_in;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_force_en;
    logic [1:0]  b_force_sel;
    logic [15:0] b_bus_out;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [1:0]  b_bus_ch;

    int n_checks = 0;
    int n_pass   = 0;

    int       m_rr;
    logic [7:0] m_bus;
    logic     m_ov;
    int       m_ch;

    always #5 clk = ~clk;

    nbit_n_one_arb_mux #(.NUM_CH(4), .DATA_WIDTH(8), .SEL_WIDTH(3)) dut (
        .clk(clk), .reset_n(reset_n), .bus_in(bus_in), .in_valid(in_valid),
        .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
        .bus_out(bus_out), .out_valid(out_valid), .out_ready(out_ready), .bus_ch(bus_ch)
    );

    nbit_n_one_arb_mux #(.NUM_CH(3), .DATA_WIDTH(16), .SEL_WIDTH(2)) dut_w (
        .clk(clk), .reset_n(reset_n), .bus_in(b_bus_in), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .force_en(b_force_en), .force_sel(b_force_sel),
        .bus_out(b_bus_out), .out_valid(b_out_valid), .out_ready(b_out_ready), .bus_ch(b_bus_ch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Channel that wins this cycle according to the arbitration rules, or -1.
    function automatic int exp_grant(input logic fe, input int fs, input logic [3:0] v,
                                     input int rr, input logic ov, input logic ordy);
        if (ov && !ordy) return -1;
        if (fe) begin
            if (fs < 4 && v[fs]) return fs;
            return -1;
        end
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (rr + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr  = 0;
        m_bus = '0;
        m_ov  = 1'b0;
        m_ch  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".bus_out"},   32'(bus_out),   32'(m_bus));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".bus_ch"},    32'(bus_ch),    32'(m_ch));
    endtask

    task automatic step(input logic [3:0] v, input logic [31:0] data, input logic fe,
                        input logic [2:0] fs, input logic ordy);
        int g;
        logic [31:0] d;
        @(negedge clk);
        in_valid  = v;
        bus_in    = data;
        force_en  = fe;
        force_sel = fs;
        out_ready = ordy;
        #1;
        g = exp_grant(fe, int'(fs), v, m_rr, m_ov, ordy);
        check("in_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        #1;
        d = data;
        if (g >= 0) begin
            m_bus = d[g*8 +: 8];
            m_ch  = g;
            m_ov  = 1'b1;
            if (!fe) m_rr = (g + 1) % 4;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        check_outputs("step");
    endtask

    task automatic mid_reset();
        @(negedge clk);
        in_valid  = 4'hF;
        out_ready = 1'b1;
        force_en  = 1'b0;
        reset_n   = 1'b0;
        #1;
        model_reset();
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus_in      = 32'hA3A2A1A0;
        in_valid    = 4'hF;
        force_en    = 1'b0;
        force_sel   = '0;
        out_ready   = 1'b1;
        b_bus_in    = '0;
        b_in_valid  = '0;
        b_force_en  = 1'b0;
        b_force_sel = '0;
        b_out_ready = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("init.in_ready", 32'(in_ready), 32'd0);
        check_outputs("init");
        reset_n = 1'b1;

        // Round-robin over all four channels, leaves rr_ptr at 2
        repeat (6) step(4'hF, 32'hA3A2A1A0, 1'b0, 3'd0, 1'b1);
        // Sparse: ch3, ch1, ch3
        repeat (3) step(4'b1010, 32'hB3B2B1B0, 1'b0, 3'd0, 1'b1);
        // Forced ch2 with backpressure
        step(4'hF, 32'h115C2211, 1'b1, 3'd2, 1'b1);
        repeat (3) step(4'hF, 32'h33443355, 1'b1, 3'd2, 1'b0);
        step(4'hF, 32'h115D2211, 1'b1, 3'd2, 1'b1);
        step(4'hF, 32'h115E2211, 1'b1, 3'd2, 1'b1);
        // Out-of-range forced select grants nothing
        step(4'hF, 32'hC3C2C1C0, 1'b1, 3'd5, 1'b1);
        step(4'hF, 32'hC3C2C1C0, 1'b1, 3'd5, 1'b1);
        // Back to round-robin from the untouched pointer
        repeat (3) step(4'hF, 32'hD3D2D1D0, 1'b0, 3'd0, 1'b1);
        // Reset with a word in the register, then first grant must be ch0
        step(4'hF, 32'hE3E2E1E0, 1'b0, 3'd0, 1'b0);
        mid_reset();
        step(4'hF, 32'hF3F2F1F0, 1'b0, 3'd0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            step(4'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end

        // 3-channel, 16-bit instance: wrap from ch2 to ch0 and full-width payload
        @(negedge clk);
        b_in_valid = 3'b100;
        b_bus_in   = {16'hBEEF, 16'h0000, 16'h1234};
        #1;
        check("w.in_ready0", 32'(b_in_ready), 32'b100);
        @(posedge clk);
        #1;
        check("w.bus_out0", 32'(b_bus_out), 32'hBEEF);
        check("w.bus_ch0", 32'(b_bus_ch), 32'd2);
        check("w.out_valid0", 32'(b_out_valid), 32'd1);
        @(negedge clk);
        b_in_valid = 3'b101;
        #1;
        check("w.in_ready1", 32'(b_in_ready), 32'b001);
        @(posedge clk);
        #1;
        check("w.bus_out1", 32'(b_bus_out), 32'h1234);
        check("w.bus_ch1", 32'(b_bus_ch), 32'd0);
        @(negedge clk);
        #1;
        check("w.in_ready2", 32'(b_in_ready), 32'b100);
        @(posedge clk);
        #1;
        check("w.bus_out2", 32'(b_bus_out), 32'hBEEF);
        @(negedge clk);
        b_in_valid = 3'b000;
        @(posedge clk);
        #1;
        check("w.out_valid3", 32'(b_out_valid), 32'd0);
        check("w.bus_out3", 32'(b_bus_out), 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
